// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by the
// program source (master) and imem_loader (slave).
interface imem_loader_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a counted, checksummed byte stream into instruction memory as
// little-endian words and releases the CPU reset once the load verifies.
module imem_loader #(
  parameter int unsigned           WIDTH       = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           DEPTH_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_lo_q;
  logic [15:0]           n_q;
  logic [15:0]           word_cnt_q;
  logic [1:0]            idx_q;
  logic [7:0]            chk_q;
  logic                  byte_ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [WIDTH-1:0]      wr_data_q;
  logic                  xfer;
  logic [15:0]           n_hdr;

  assign xfer  = bus.byte_valid & byte_ready_q;
  assign n_hdr = {bus.byte_data, cnt_lo_q};

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR0: if (xfer) state_d = HDR1;
      HDR1: begin
        if (xfer) begin
          if (32'(n_hdr) > DEPTH_WORDS) state_d = ERR;
          else if (n_hdr == 16'd0)      state_d = CHK;
          else                          state_d = DATA;
        end
      end
      DATA:  if (xfer && idx_q == 2'd3) state_d = WRITE;
      WRITE: state_d = ((word_cnt_q + 16'd1) == n_q) ? CHK : DATA;
      CHK: begin
        if (xfer) state_d = (bus.byte_data == chk_q) ? DONE : ERR;
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = HDR0;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe, keeping byte_ready free of any path
  // from byte_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= HDR0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      cnt_lo_q     <= '0;
      n_q          <= '0;
      word_cnt_q   <= '0;
      idx_q        <= '0;
      chk_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= state_d inside {HDR0, HDR1, DATA, CHK};
      wr_en_q      <= (state_d == WRITE);
      cpu_rst      <= (state_d != DONE);
      done         <= (state_d == DONE);
      err          <= (state_d == ERR);

      if (xfer) begin
        unique case (state_q)
          HDR0: cnt_lo_q <= bus.byte_data;
          HDR1: n_q      <= n_hdr;
          DATA: begin
            wr_data_q[{idx_q, 3'b000} +: 8] <= bus.byte_data;
            chk_q <= chk_q ^ bus.byte_data;
            idx_q <= idx_q + 2'd1;
          end
          default: ;
        endcase
      end

      if (state_q == WRITE) begin
        wr_addr_q  <= wr_addr_q + ADDR_WIDTH'(4);
        word_cnt_q <= word_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader with a few multi-cycle
// sequences for idle, stalls, reset mid-load and post-done behaviour.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_rst, done, err;

  imem_loader_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

  imem_loader #(
    .WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .DEPTH_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic mon_on = 1'b0;
  logic [63:0] wq [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.wr_en === 1'b1) begin
        wq.push_back({bus.wr_addr, bus.wr_data});
        check("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
      end
      check("done_err_exclusive", 64'(done & err), 64'd0);
    end
  end

  typedef struct packed {
    logic [0:19][7:0]  b;
    logic [4:0]        len;
    logic [0:3][31:0]  w;
    logic [2:0]        nwr;
    logic              exp_done;
    logic              exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic send_byte(input logic [7:0] b);
    int unsigned t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", 64'(t), 64'd0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic gap(input int unsigned n);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_writes(input vec_t v, input string tag);
    check({tag, "_nwrites"}, 64'(wq.size()), 64'(v.nwr));
    for (int k = 0; k < int'(v.nwr); k++) begin
      if (k < wq.size())
        check({tag, "_write"}, wq[k], {BASE + 32'(4 * k), v.w[k]});
    end
  endtask

  initial begin
    int t0;
    vec_t v;

    // byte lists are padded to 20 entries; good checksum of the two-word
    // program is 13^05^A0^00^93^05^10^00 = 0x30
    vecs[0] = '{b: {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00, 8'h30, {9{8'h00}}},
                len: 5'd11, w: {32'h00A00513, 32'h00100593, 64'h0}, nwr: 3'd2, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{b: {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00, 8'h31, {9{8'h00}}},
                len: 5'd11, w: {32'h00A00513, 32'h00100593, 64'h0}, nwr: 3'd2, exp_done: 1'b0, exp_err: 1'b1};
    vecs[2] = '{b: {8'h05, 8'h00, {18{8'h00}}},
                len: 5'd2, w: '0, nwr: 3'd0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{b: {8'h00, 8'h00, 8'h00, {17{8'h00}}},
                len: 5'd3, w: '0, nwr: 3'd0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{b: {8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                    8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h10, 8'h00},
                len: 5'd19, w: {32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D},
                nwr: 3'd4, exp_done: 1'b1, exp_err: 1'b0};
    vecs[5] = '{b: {8'h00, 8'h00, 8'h01, {17{8'h00}}},
                len: 5'd3, w: '0, nwr: 3'd0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[6] = '{b: {8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, {13{8'h00}}},
                len: 5'd7, w: {32'h000000FF, 96'h0}, nwr: 3'd1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[7] = '{b: {8'h00, 8'h01, {18{8'h00}}},
                len: 5'd2, w: '0, nwr: 3'd0, exp_done: 1'b0, exp_err: 1'b1};

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // reset state, then idle
    repeat (2) @(negedge clk);
    check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("rst_wr_en",      64'(bus.wr_en),      64'd0);
    check("rst_wr_addr",    64'(bus.wr_addr),    64'(BASE));
    check("rst_wr_data",    64'(bus.wr_data),    64'd0);
    check("rst_cpu_rst",    64'(cpu_rst),        64'd1);
    check("rst_done",       64'(done),           64'd0);
    check("rst_err",        64'(err),            64'd0);
    mon_on = 1'b1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_byte_ready", 64'(bus.byte_ready), 64'd1);
    check("idle_cpu_rst",    64'(cpu_rst),        64'd1);
    check("idle_done",       64'(done),           64'd0);
    check("idle_err",        64'(err),            64'd0);
    check("idle_nwrites",    64'(wq.size()),      64'd0);

    // table: back-to-back streams
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      do_reset();
      wq.delete();
      t0 = cyc;
      for (int j = 0; j < int'(v.len); j++) send_byte(v.b[j]);
      check("load_cycles", 64'(cyc - t0), 64'(int'(v.len) + int'(v.nwr)));
      check("vec_done",    64'(done),           64'(v.exp_done));
      check("vec_err",     64'(err),            64'(v.exp_err));
      check("vec_cpu_rst", 64'(cpu_rst),        64'(!v.exp_done));
      check("vec_ready",   64'(bus.byte_ready), 64'd0);
      check_writes(v, "vec");
    end

    // stalls between bytes
    v = vecs[0];
    do_reset();
    wq.delete();
    for (int j = 0; j < int'(v.len); j++) begin
      gap($urandom_range(0, 3));
      send_byte(v.b[j]);
    end
    check("stall_done", 64'(done), 64'd1);
    check_writes(v, "stall");

    // reset partway into the second word, then restream
    do_reset();
    wq.delete();
    for (int j = 0; j < 7; j++) send_byte(v.b[j]);
    gap(2);
    check("partial_nwrites", 64'(wq.size()), 64'd1);
    do_reset();
    wq.delete();
    for (int j = 0; j < int'(v.len); j++) send_byte(v.b[j]);
    check("restream_done", 64'(done), 64'd1);
    check_writes(v, "restream");

    // bytes offered after done are never taken
    wq.delete();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("post_ready", 64'(bus.byte_ready), 64'd0);
    end
    bus.byte_valid = 1'b0;
    check("post_nwrites", 64'(wq.size()), 64'd0);
    check("post_done",    64'(done),      64'd1);
    check("post_cpu_rst", 64'(cpu_rst),   64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
